// File: rtl/arm_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// arm_ctrl_pkg
// Shared types and helpers for the ARM pipelined control unit.
//   cond_e      : ARM condition field encodings (EQ..AL, NV).
//   FWD_*       : operand forwarding select codes.
//   ctrl_t      : per-stage control bundle (controls, Cond, register numbers).
//                 The ALU control field is ALUW bits wide, set by a parameter
//                 of the top, so it travels beside ctrl_t rather than inside.
//   dest_hit    : stage writes a register read by the Decode instruction.
//   load_hit    : same, restricted to loads.
//   fwd_select  : priority encoder for the forwarding mux select.
// ---------------------------------------------------------------------------
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    localparam logic [1:0] FWD_RF = 2'b00;  // register file operand
    localparam logic [1:0] FWD_W  = 2'b01;  // Writeback result
    localparam logic [1:0] FWD_M  = 2'b10;  // first Memory stage ALU result

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       pc_src;
        logic       alu_src;
        logic [1:0] flag_write;
        logic [3:0] cond;
        logic [3:0] ra1;
        logic [3:0] ra2;
        logic [3:0] wa3;
    } ctrl_t;

    function automatic logic dest_hit(input ctrl_t s, input logic [3:0] ra1,
                                      input logic [3:0] ra2);
        return s.reg_write & ((s.wa3 == ra1) | (s.wa3 == ra2));
    endfunction

    function automatic logic load_hit(input ctrl_t s, input logic [3:0] ra1,
                                      input logic [3:0] ra2);
        return s.mem_to_reg & dest_hit(s, ra1, ra2);
    endfunction

    function automatic logic [1:0] fwd_select(input logic hit_m, input logic hit_w);
        logic [1:0] sel;
        if (hit_m) begin
            sel = FWD_M;
        end else if (hit_w) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/arm_cond_check.sv
// ---------------------------------------------------------------------------
// arm_cond_check
// Combinational ARM condition evaluation.
//   i_cond    in  4  instruction condition field
//   i_flags   in  4  {N,Z,C,V}
//   o_cond_ex out 1  condition passes (NV always fails)
// ---------------------------------------------------------------------------
module arm_cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_cond_ex
);

    logic w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = i_flags;

    // Decode the condition field against the current flags.
    always_comb begin
        o_cond_ex = 1'b0;
        case (cond_e'(i_cond))
            EQ:      o_cond_ex = w_z;
            NE:      o_cond_ex = ~w_z;
            CS:      o_cond_ex = w_c;
            CC:      o_cond_ex = ~w_c;
            MI:      o_cond_ex = w_n;
            PL:      o_cond_ex = ~w_n;
            VS:      o_cond_ex = w_v;
            VC:      o_cond_ex = ~w_v;
            HI:      o_cond_ex = w_c & ~w_z;
            LS:      o_cond_ex = ~w_c | w_z;
            GE:      o_cond_ex = (w_n == w_v);
            LT:      o_cond_ex = (w_n != w_v);
            GT:      o_cond_ex = ~w_z & (w_n == w_v);
            LE:      o_cond_ex = w_z | (w_n != w_v);
            AL:      o_cond_ex = 1'b1;
            NV:      o_cond_ex = 1'b0;
            default: o_cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// arm_pipe_ctrl
// Pipelined control unit: carries decoded controls D -> E -> M1..Mk -> W,
// evaluates conditions and updates the flags in Execute, and produces
// stall / flush / forwarding controls for the datapath.
//
// Parameters: ALUW (ALU control width), MEM_STAGES (k, 1..3).
// Inputs : clk, reset (sync, active high), RegWriteD, MemWriteD, MemtoRegD,
//          BranchD, PCSrcD, ALUSrcD, FlagWriteD[1:0], ALUControlD, CondD,
//          RA1D, RA2D, WA3D, ALUFlagsE {N,Z,C,V}.
// Outputs: ALUSrcE, ALUControlE, MemWriteM (from Mk), MemtoRegW, RegWriteW,
//          PCSrcW, WA3W, BranchTakenE, StallF, StallD, FlushD, FlushE,
//          ForwardAE, ForwardBE, FlagsQ.
//
// Build option ARM_PIPE_CTRL_FORWARD_EN: when defined, operands forward from
// M1/W and only load-use hazards stall. When undefined, forwarding selects
// are held at 00 and Decode stalls on any in-flight write (E..Mk, W) to one
// of its source registers.
// ---------------------------------------------------------------------------
module arm_pipe_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter int ALUW       = 3,
    parameter int MEM_STAGES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            MemtoRegD,
    input  logic            BranchD,
    input  logic            PCSrcD,
    input  logic            ALUSrcD,
    input  logic [1:0]      FlagWriteD,
    input  logic [ALUW-1:0] ALUControlD,
    input  logic [3:0]      CondD,
    input  logic [3:0]      RA1D,
    input  logic [3:0]      RA2D,
    input  logic [3:0]      WA3D,
    input  logic [3:0]      ALUFlagsE,
    output logic            ALUSrcE,
    output logic [ALUW-1:0] ALUControlE,
    output logic            MemWriteM,
    output logic            MemtoRegW,
    output logic            RegWriteW,
    output logic            PCSrcW,
    output logic [3:0]      WA3W,
    output logic            BranchTakenE,
    output logic            StallF,
    output logic            StallD,
    output logic            FlushD,
    output logic            FlushE,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE,
    output logic [3:0]      FlagsQ
);

    ctrl_t                  w_ctrl_d;
    ctrl_t                  r_e;
    logic [ALUW-1:0]        r_alu_ctrl_e;
    ctrl_t                  w_ctrl_m1_in;
    ctrl_t [MEM_STAGES-1:0] w_m;
    ctrl_t                  r_w;
    logic [3:0]             r_flags;
    logic                   w_cond_ex;
    logic                   w_branch_taken;
    logic                   w_ld_stall;
    logic                   w_pc_wr_pend;
    logic                   w_flush_e;
    logic                   w_unused;

    assign w_ctrl_d = '{reg_write:  RegWriteD,
                        mem_write:  MemWriteD,
                        mem_to_reg: MemtoRegD,
                        branch:     BranchD,
                        pc_src:     PCSrcD,
                        alu_src:    ALUSrcD,
                        flag_write: FlagWriteD,
                        cond:       CondD,
                        ra1:        RA1D,
                        ra2:        RA2D,
                        wa3:        WA3D};

    // D->E register; a flush (load-use bubble or taken branch) loads zero controls.
    always_ff @(posedge clk) begin
        if (reset || w_flush_e) begin
            r_e          <= '0;
            r_alu_ctrl_e <= '0;
        end else begin
            r_e          <= w_ctrl_d;
            r_alu_ctrl_e <= ALUControlD;
        end
    end

    arm_cond_check u_cond (
        .i_cond    (r_e.cond),
        .i_flags   (r_flags),
        .o_cond_ex (w_cond_ex)
    );

    // Architectural side effects leaving Execute are squashed when the condition fails.
    always_comb begin
        w_ctrl_m1_in           = r_e;
        w_ctrl_m1_in.reg_write = r_e.reg_write & w_cond_ex;
        w_ctrl_m1_in.mem_write = r_e.mem_write & w_cond_ex;
        w_ctrl_m1_in.pc_src    = r_e.pc_src & w_cond_ex;
    end

    // Flags register: NZ and CV halves written independently, only if the condition passes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else begin
            if (r_e.flag_write[1] & w_cond_ex) begin
                r_flags[3:2] <= ALUFlagsE[3:2];
            end
            if (r_e.flag_write[0] & w_cond_ex) begin
                r_flags[1:0] <= ALUFlagsE[1:0];
            end
        end
    end

    for (genvar g = 0; g < MEM_STAGES; g++) begin : gen_mem
        ctrl_t r_stage;
        ctrl_t w_stage_in;

        if (g == 0) begin : gen_first
            assign w_stage_in = w_ctrl_m1_in;
        end else begin : gen_next
            assign w_stage_in = w_m[g-1];
        end

        // Memory stage register; these stages never stall.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_stage <= '0;
            end else begin
                r_stage <= w_stage_in;
            end
        end

        assign w_m[g] = r_stage;
    end

    // Mk->W register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_w <= '0;
        end else begin
            r_w <= w_m[MEM_STAGES-1];
        end
    end

    // Hazard detection: data hazards on Decode sources and pending PC writes.
    always_comb begin
        w_pc_wr_pend = PCSrcD | r_e.pc_src;
        w_ld_stall   = 1'b0;
        for (int i = 0; i < MEM_STAGES; i++) begin
            w_pc_wr_pend = w_pc_wr_pend | w_m[i].pc_src;
        end
`ifdef ARM_PIPE_CTRL_FORWARD_EN
        // A load in Mk reaches W next cycle and is forwarded from there, so Mk is exempt.
        w_ld_stall = load_hit(r_e, RA1D, RA2D);
        for (int i = 0; i < MEM_STAGES - 1; i++) begin
            w_ld_stall = w_ld_stall | load_hit(w_m[i], RA1D, RA2D);
        end
`else
        // No bypass network: wait until every matching write has left W.
        w_ld_stall = dest_hit(r_e, RA1D, RA2D) | dest_hit(r_w, RA1D, RA2D);
        for (int i = 0; i < MEM_STAGES; i++) begin
            w_ld_stall = w_ld_stall | dest_hit(w_m[i], RA1D, RA2D);
        end
`endif
    end

`ifdef ARM_PIPE_CTRL_FORWARD_EN
    // M1 loads have no data yet, so only ALU results forward from M1; M1 wins over W.
    assign ForwardAE = fwd_select(w_m[0].reg_write & ~w_m[0].mem_to_reg &
                                  (w_m[0].wa3 == r_e.ra1),
                                  r_w.reg_write & (r_w.wa3 == r_e.ra1));
    assign ForwardBE = fwd_select(w_m[0].reg_write & ~w_m[0].mem_to_reg &
                                  (w_m[0].wa3 == r_e.ra2),
                                  r_w.reg_write & (r_w.wa3 == r_e.ra2));
`else
    assign ForwardAE = FWD_RF;
    assign ForwardBE = FWD_RF;
`endif

    // A taken branch squashes the Decode instruction, so stalling it is pointless.
    assign w_branch_taken = r_e.branch & w_cond_ex;
    assign w_flush_e      = w_ld_stall | w_branch_taken;

    assign BranchTakenE = w_branch_taken;
    assign StallF       = (w_ld_stall | w_pc_wr_pend) & ~w_branch_taken;
    assign StallD       = w_ld_stall & ~w_branch_taken;
    assign FlushE       = w_flush_e;
    assign FlushD       = w_pc_wr_pend | w_branch_taken;

    assign ALUSrcE     = r_e.alu_src;
    assign ALUControlE = r_alu_ctrl_e;
    assign MemWriteM   = w_m[MEM_STAGES-1].mem_write;
    assign MemtoRegW   = r_w.mem_to_reg;
    assign RegWriteW   = r_w.reg_write;
    assign PCSrcW      = r_w.pc_src;
    assign WA3W        = r_w.wa3;
    assign FlagsQ      = r_flags;

    // Bundle fields that are carried for uniformity but not consumed in every stage.
    assign w_unused = ^{r_e, w_m, r_w};

endmodule

// File: tb/tb_arm_pipe_ctrl.sv
`timescale 1ns/1ps
module tb_arm_pipe_ctrl;

    localparam int ALUW = 3;
`ifdef ARM_PIPE_CTRL_FORWARD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    localparam logic [3:0] C_EQ = 4'b0000, C_NE = 4'b0001, C_CS = 4'b0010,
                           C_CC = 4'b0011, C_MI = 4'b0100, C_PL = 4'b0101,
                           C_VS = 4'b0110, C_VC = 4'b0111, C_HI = 4'b1000,
                           C_LS = 4'b1001, C_GE = 4'b1010, C_LT = 4'b1011,
                           C_GT = 4'b1100, C_LE = 4'b1101, C_AL = 4'b1110,
                           C_NV = 4'b1111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            RegWriteD, MemWriteD, MemtoRegD, BranchD, PCSrcD, ALUSrcD;
    logic [1:0]      FlagWriteD;
    logic [ALUW-1:0] ALUControlD;
    logic [3:0]      CondD, RA1D, RA2D, WA3D, ALUFlagsE;

    logic            k1_ALUSrcE, k1_MemWriteM, k1_MemtoRegW, k1_RegWriteW, k1_PCSrcW;
    logic [ALUW-1:0] k1_ALUControlE;
    logic [3:0]      k1_WA3W, k1_FlagsQ;
    logic            k1_BranchTakenE, k1_StallF, k1_StallD, k1_FlushD, k1_FlushE;
    logic [1:0]      k1_ForwardAE, k1_ForwardBE;

    logic            k3_ALUSrcE, k3_MemWriteM, k3_MemtoRegW, k3_RegWriteW, k3_PCSrcW;
    logic [ALUW-1:0] k3_ALUControlE;
    logic [3:0]      k3_WA3W, k3_FlagsQ;
    logic            k3_BranchTakenE, k3_StallF, k3_StallD, k3_FlushD, k3_FlushE;
    logic [1:0]      k3_ForwardAE, k3_ForwardBE;

    arm_pipe_ctrl #(.ALUW(ALUW), .MEM_STAGES(1)) dut1 (
        .clk(clk), .reset(reset),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .MemtoRegD(MemtoRegD),
        .BranchD(BranchD), .PCSrcD(PCSrcD), .ALUSrcD(ALUSrcD),
        .FlagWriteD(FlagWriteD), .ALUControlD(ALUControlD), .CondD(CondD),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D), .ALUFlagsE(ALUFlagsE),
        .ALUSrcE(k1_ALUSrcE), .ALUControlE(k1_ALUControlE), .MemWriteM(k1_MemWriteM),
        .MemtoRegW(k1_MemtoRegW), .RegWriteW(k1_RegWriteW), .PCSrcW(k1_PCSrcW),
        .WA3W(k1_WA3W), .BranchTakenE(k1_BranchTakenE), .StallF(k1_StallF),
        .StallD(k1_StallD), .FlushD(k1_FlushD), .FlushE(k1_FlushE),
        .ForwardAE(k1_ForwardAE), .ForwardBE(k1_ForwardBE), .FlagsQ(k1_FlagsQ)
    );

    arm_pipe_ctrl #(.ALUW(ALUW), .MEM_STAGES(3)) dut3 (
        .clk(clk), .reset(reset),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .MemtoRegD(MemtoRegD),
        .BranchD(BranchD), .PCSrcD(PCSrcD), .ALUSrcD(ALUSrcD),
        .FlagWriteD(FlagWriteD), .ALUControlD(ALUControlD), .CondD(CondD),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D), .ALUFlagsE(ALUFlagsE),
        .ALUSrcE(k3_ALUSrcE), .ALUControlE(k3_ALUControlE), .MemWriteM(k3_MemWriteM),
        .MemtoRegW(k3_MemtoRegW), .RegWriteW(k3_RegWriteW), .PCSrcW(k3_PCSrcW),
        .WA3W(k3_WA3W), .BranchTakenE(k3_BranchTakenE), .StallF(k3_StallF),
        .StallD(k3_StallD), .FlushD(k3_FlushD), .FlushE(k3_FlushE),
        .ForwardAE(k3_ForwardAE), .ForwardBE(k3_ForwardBE), .FlagsQ(k3_FlagsQ)
    );

    typedef struct packed {
        logic [3:0] flags;
        logic [3:0] cond;
        logic       taken;
    } br_vec_t;

    br_vec_t vecs [21];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic mw, input logic m2r, input logic br,
                         input logic pcs, input logic alus, input logic [1:0] fw,
                         input logic [2:0] aluc, input logic [3:0] cond,
                         input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3);
        RegWriteD = rw;  MemWriteD = mw;  MemtoRegD = m2r; BranchD = br;
        PCSrcD = pcs;    ALUSrcD = alus;  FlagWriteD = fw; ALUControlD = aluc;
        CondD = cond;    RA1D = ra1;      RA2D = ra2;      WA3D = wa3;
        #1;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 4'b0000,
              4'd0, 4'd0, 4'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ALUFlagsE = 4'b0000;
        nop();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Producer writes R<rd> (load or ALU op), consumer reads it as source A.
    task automatic hazard_seq(input string tag, input bit use3, input bit is_load,
                              input logic [3:0] rd, input int exp_cycles,
                              input logic [1:0] exp_fwd);
        int n;
        do_reset();
        drive(1'b1, 1'b0, is_load, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, C_AL, 4'd0, 4'd0, rd);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b010, C_AL, rd, 4'd1, 4'd6);
        n = 0;
        while (((use3 ? k3_StallD : k1_StallD) === 1'b1) && n < 20) begin
            check({tag, "_stallF"}, {31'd0, use3 ? k3_StallF : k1_StallF}, 32'd1);
            check({tag, "_flushE"}, {31'd0, use3 ? k3_FlushE : k1_FlushE}, 32'd1);
            n++;
            tick();
        end
        check({tag, "_stall_cycles"}, n, exp_cycles);
        tick();
        nop();
        check({tag, "_fwdA"}, {30'd0, use3 ? k3_ForwardAE : k1_ForwardAE}, {30'd0, exp_fwd});
        check({tag, "_fwdB"}, {30'd0, use3 ? k3_ForwardBE : k1_ForwardBE}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        vecs[0]  = '{4'b0100, C_EQ, 1'b1};  vecs[1]  = '{4'b0000, C_EQ, 1'b0};
        vecs[2]  = '{4'b0100, C_NE, 1'b0};  vecs[3]  = '{4'b0000, C_NE, 1'b1};
        vecs[4]  = '{4'b0010, C_CS, 1'b1};  vecs[5]  = '{4'b0010, C_CC, 1'b0};
        vecs[6]  = '{4'b1000, C_MI, 1'b1};  vecs[7]  = '{4'b1000, C_PL, 1'b0};
        vecs[8]  = '{4'b0001, C_VS, 1'b1};  vecs[9]  = '{4'b0000, C_VC, 1'b1};
        vecs[10] = '{4'b0010, C_HI, 1'b1};  vecs[11] = '{4'b0110, C_HI, 1'b0};
        vecs[12] = '{4'b0110, C_LS, 1'b1};  vecs[13] = '{4'b1001, C_GE, 1'b1};
        vecs[14] = '{4'b1000, C_LT, 1'b1};  vecs[15] = '{4'b0000, C_GT, 1'b1};
        vecs[16] = '{4'b0100, C_GT, 1'b0};  vecs[17] = '{4'b0100, C_LE, 1'b1};
        vecs[18] = '{4'b0000, C_LE, 1'b0};  vecs[19] = '{4'b0000, C_AL, 1'b1};
        vecs[20] = '{4'b1111, C_NV, 1'b0};

        // Reset state: every output low with idle Decode inputs.
        do_reset();
        nop();
        check("reset_k1", {k1_ALUSrcE, k1_ALUControlE, k1_MemWriteM, k1_MemtoRegW,
                           k1_RegWriteW, k1_PCSrcW, k1_WA3W, k1_BranchTakenE, k1_StallF,
                           k1_StallD, k1_FlushD, k1_FlushE, k1_ForwardAE, k1_ForwardBE,
                           k1_FlagsQ}, 32'd0);
        check("reset_k3", {k3_ALUSrcE, k3_ALUControlE, k3_MemWriteM, k3_MemtoRegW,
                           k3_RegWriteW, k3_PCSrcW, k3_WA3W, k3_BranchTakenE, k3_StallF,
                           k3_StallD, k3_FlushD, k3_FlushE, k3_ForwardAE, k3_ForwardBE,
                           k3_FlagsQ}, 32'd0);

        // Latency: E after 1, MemWriteM after 1+k, W after 2+k.
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 3'b101, C_AL, 4'd0, 4'd0, 4'd5);
        tick();
        nop();
        check("lat_E", {k1_ALUSrcE, k1_ALUControlE}, {28'd0, 1'b1, 3'b101});
        check("lat_k1_M_early", {31'd0, k1_MemWriteM}, 32'd0);
        tick();
        check("lat_k1_M", {31'd0, k1_MemWriteM}, 32'd1);
        check("lat_k3_M_early", {31'd0, k3_MemWriteM}, 32'd0);
        tick();
        check("lat_k1_W", {k1_MemtoRegW, k1_RegWriteW, k1_WA3W}, {26'd0, 2'b11, 4'd5});
        tick();
        check("lat_k3_M", {31'd0, k3_MemWriteM}, 32'd1);
        check("lat_k1_W_gone", {31'd0, k1_RegWriteW}, 32'd0);
        tick();
        check("lat_k3_W", {k3_MemtoRegW, k3_RegWriteW, k3_WA3W}, {26'd0, 2'b11, 4'd5});

        // Failed condition (EQ with Z=0) squashes RegWrite/MemWrite/PCSrc past E.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, C_EQ, 4'd0, 4'd0, 4'd6);
        tick();
        nop();
        check("gate_flushD_E", {31'd0, k1_FlushD}, 32'd1);
        tick();
        check("gate_memwrite", {31'd0, k1_MemWriteM}, 32'd0);
        check("gate_flushD_M", {31'd0, k1_FlushD}, 32'd0);
        tick();
        check("gate_W", {k1_RegWriteW, k1_PCSrcW}, 32'd0);

        // Data hazards.
        hazard_seq("add_sub_k1", 1'b0, 1'b0, 4'd2, FWD_ON ? 0 : 3,
                   FWD_ON ? 2'b10 : 2'b00);
        hazard_seq("ldr_add_k1", 1'b0, 1'b1, 4'd3, FWD_ON ? 1 : 3,
                   FWD_ON ? 2'b01 : 2'b00);
        hazard_seq("ldr_add_k3", 1'b1, 1'b1, 4'd3, FWD_ON ? 3 : 5,
                   FWD_ON ? 2'b01 : 2'b00);

        // Condition table: flag-setting op, then a branch evaluated on the new flags.
        do_reset();
        for (int i = 0; i < 21; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'b001, C_AL, 4'd0, 4'd0, 4'd0);
            tick();
            ALUFlagsE = vecs[i].flags;
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000, vecs[i].cond,
                  4'd0, 4'd0, 4'd0);
            tick();
            ALUFlagsE = 4'b0000;
            nop();
            check($sformatf("br%0d_flags", i), {28'd0, k1_FlagsQ}, {28'd0, vecs[i].flags});
            check($sformatf("br%0d_taken", i), {31'd0, k1_BranchTakenE}, {31'd0, vecs[i].taken});
            check($sformatf("br%0d_flushD", i), {31'd0, k1_FlushD}, {31'd0, vecs[i].taken});
            check($sformatf("br%0d_flushE", i), {31'd0, k1_FlushE}, {31'd0, vecs[i].taken});
            tick();
            tick();
        end

        // Partial flag writes and a failing condition that must not write flags.
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'b001, C_AL, 4'd0, 4'd0, 4'd0);
        tick();
        ALUFlagsE = 4'b1111;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b001, C_AL, 4'd0, 4'd0, 4'd0);
        tick();
        ALUFlagsE = 4'b0000;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'b001, C_NE, 4'd0, 4'd0, 4'd0);
        check("flags_all", {28'd0, k1_FlagsQ}, 32'hF);
        tick();
        nop();
        check("flags_cv_only", {28'd0, k1_FlagsQ}, 32'hC);
        tick();
        check("flags_cond_fail", {28'd0, k1_FlagsQ}, 32'hC);

        // Load-use hazard coincident with a taken branch (k=3: load in M1).
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, C_AL, 4'd0, 4'd0, 4'd3);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000, C_AL, 4'd0, 4'd0, 4'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b010, C_AL, 4'd3, 4'd1, 4'd6);
        check("ldbr_hazards", {k3_BranchTakenE, k3_StallF, k3_StallD, k3_FlushD, k3_FlushE},
              32'b10011);

        // PC write pending from D through M1 (k=1), then PCSrcW.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, C_AL, 4'd0, 4'd0, 4'd15);
        check("pcw_D", {k1_StallF, k1_StallD, k1_FlushD, k1_FlushE}, 32'b1010);
        tick();
        nop();
        n = 0;
        while (k1_FlushD === 1'b1 && n < 10) begin
            n++;
            tick();
        end
        check("pcw_pending_cycles", n, 32'd2);
        check("pcw_W", {k1_PCSrcW, k1_RegWriteW, k1_WA3W}, {26'd0, 2'b11, 4'd15});

        // Reset with three instructions in flight.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'b000, C_AL, 4'd0, 4'd0, 4'd1);
        tick();
        ALUFlagsE = 4'b1010;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, C_AL, 4'd0, 4'd0, 4'd2);
        tick();
        ALUFlagsE = 4'b0000;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000, C_AL, 4'd0, 4'd0, 4'd4);
        tick();
        nop();
        check("inflight_pre", {k1_RegWriteW, k1_WA3W, k1_FlagsQ}, {23'd0, 1'b1, 4'd1, 4'b1010});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("inflight_reset", {k1_MemtoRegW, k1_RegWriteW, k1_PCSrcW, k1_WA3W, k1_FlagsQ,
                                 k1_MemWriteM, k1_ALUSrcE}, 32'd0);
        check("inflight_reset_k3", {k3_RegWriteW, k3_WA3W, k3_FlagsQ, k3_MemWriteM}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("no_stray_%0d", i), {k1_RegWriteW, k1_MemWriteM,
                                                 k3_RegWriteW, k3_MemWriteM}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arm_pipe_ctrl.md
# arm_pipe_ctrl

Parametrised pipelined control unit for the ARM pipelined processor. It carries decoded control signals from Decode through Execute, a configurable number of Memory stages, and Writeback. It evaluates condition codes against an internal flags register in Execute, and generates hazard control: stall, flush and operand forwarding. It sits between the decoder and the pipelined datapath. It replaces a fixed-depth control pipeline whose enable is hard-wired high.

## Interface
Parameters:
- ALUW, 3, width of the ALU control field.
- MEM_STAGES, 1, number of Memory stages; legal range 1..3.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- RegWriteD, MemWriteD, MemtoRegD, BranchD, PCSrcD, ALUSrcD  in  1 each  decoded controls.
- FlagWriteD  in  2  bit 1 updates N,Z; bit 0 updates C,V.
- ALUControlD  in  ALUW  ALU operation.
- CondD  in  4  instruction condition field.
- RA1D, RA2D, WA3D  in  4 each  source and destination register numbers.
- ALUFlagsE  in  4  {N,Z,C,V} from the Execute ALU.
- ALUSrcE  out  1  Execute-stage control.
- ALUControlE  out  ALUW  Execute-stage control.
- MemWriteM  out  1  from the last Memory stage.
- MemtoRegW, RegWriteW, PCSrcW  out  1 each  Writeback controls.
- WA3W  out  4  Writeback destination register.
- BranchTakenE  out  1  branch taken in Execute.
- StallF, StallD, FlushD, FlushE  out  1 each  hazard controls.
- ForwardAE, ForwardBE  out  2 each  operand forwarding selects.
- FlagsQ  out  4  architectural flags register.

## Operation
- Stage registers:
  - D→E, E→M1, M1→…→Mk, Mk→W, with k = MEM_STAGES.
  - Each register holds the control bits, Cond and the register numbers.
- CondEx is computed in Execute from CondE and FlagsQ. All 15 ARM conditions are supported. Code 1111 evaluates false.
- Gating by CondEx:
  - RegWrite, MemWrite and PCSrc entering M1 are ANDed with CondEx.
  - BranchTakenE = BranchE & CondEx.
- Flags update:
  - FlagsQ[3:2] ← ALUFlagsE[3:2] when FlagWriteE[1] & CondEx.
  - FlagsQ[1:0] ← ALUFlagsE[1:0] when FlagWriteE[0] & CondEx.
- Forwarding for source A (B is identical, using RA2E):
  - 10 when RegWriteM1 & WA3M1==RA1E & !MemtoRegM1.
  - 01 when RegWriteW & WA3W==RA1E.
  - 00 otherwise. The M1 match has priority.
- Load-use stall: LdStall = some stage s in {E, M1..M(k-1)} has MemtoReg & RegWrite, and WA3s equals RA1D or RA2D.
- PC-write stall: PCWrPend = PCSrc set in D, E or any M stage.
- Hazard outputs:
  - StallF = LdStall | PCWrPend.
  - StallD = LdStall.
  - FlushE = LdStall | BranchTakenE.
  - FlushD = PCWrPend | BranchTakenE.
- Override: if BranchTakenE, StallF and StallD are forced to 0, because the stalled instruction is squashed.
- A flush loads zero controls into the target register (a bubble). Flush overrides stall.

## Timing
- Reset: every stage control bit is 0, FlagsQ = 0000, and all outputs are 0.
- Reset applied mid-operation empties the pipeline on the next edge.
- Latency:
  - D-stage controls appear at E outputs 1 cycle later.
  - They appear at MemWriteM after 1+k cycles and at W outputs after 2+k cycles.
- Hazard, forward and BranchTakenE outputs are combinational within the cycle.
- Flags written by an instruction are visible to the next instruction's CondEx one cycle later. There is no same-cycle flag bypass.
- A load-use stall lasts until the load reaches W: 1 cycle when k=1, up to k cycles in general.

## Configuration
- Macro: ARM_PIPE_CTRL_FORWARD_EN.
- Defined: forwarding behaves as described in Operation.
- Undefined:
  - ForwardAE and ForwardBE are tied to 00.
  - LdStall also asserts for any RegWrite stage in E..Mk or W whose WA3 matches RA1D or RA2D, regardless of MemtoReg.

## Structure
- Package arm_ctrl_pkg:
  - cond_e enum (EQ…AL, NV).
  - Forward-select constants FWD_RF, FWD_W, FWD_M.
  - ctrl_t packed struct for the per-stage bundle; ALUW is passed as a parameter.
- Sub-module arm_cond_check: combinational function of (Cond, Flags) producing CondEx.
- Memory stages are generated in a loop over MEM_STAGES.

## Test plan
- ADD (RegWrite=1, WA3=2) followed by SUB with RA1=2 -> ForwardAE=10 in the SUB's Execute cycle; with the macro undefined, StallD=1 for the required cycles instead.
- LDR to R3, then ADD reading R3, with MEM_STAGES=1 -> StallF=StallD=FlushE=1 for exactly 1 cycle, then ForwardAE=01.
- Same sequence with MEM_STAGES=3 -> stall lasts 3 cycles.
- CMP setting Z (ALUFlagsE=0100, FlagWrite=11), then BEQ -> FlagsQ=0100, BranchTakenE=1, FlushD=FlushE=1; BNE in the same position -> no flush.
- Load-use hazard coincident with BranchTakenE -> StallD=0, StallF=0, FlushD=FlushE=1.
- Pulse reset while 3 instructions are in flight -> all W outputs and FlagsQ read 0 after the edge; no stray RegWriteW afterwards.
